riscv_commit_checker: RTL and testbench
=======================================

Name: riscv_commit_checker

Overview:
- Synthesisable self-checking run controller for the pipelined RISC-V core. It replaces hand-poked instruction memory, fixed-time finish and `$monitor` scraping.
- Loads a program into instruction memory through a handshake and loads an ordered table of expected register writebacks.
- Holds the core in reset while loading, then releases it and checks every writeback in commit order against the table.
- Reports PASS, FAIL (with failing index) or TIMEOUT.

Parameters:
- XLEN, 32, data/instruction width
- IMEM_AW, 6, instruction memory word-address width (64 words)
- NUM_CHECKS, 8, expected-writeback table depth
- TIMEOUT, 200, maximum RUN cycles before TIMEOUT
- CNT_W, 16, cycle counter width (must satisfy 2^CNT_W > TIMEOUT)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse that begins a run
- num_exp  in  $clog2(NUM_CHECKS+1)  number of valid table entries; sampled on start
- ld_valid  in  1  load request
- ld_ready  out  1  load accepted when ld_valid && ld_ready
- ld_sel  in  1  load target: 0 = imem, 1 = expect table
- ld_addr  in  IMEM_AW  imem word address, or table index (low bits)
- ld_rd  in  5  expected destination register (ld_sel=1 only)
- ld_data  in  XLEN  instruction word or expected value
- imem_we  out  1  imem write strobe
- imem_addr  out  IMEM_AW  imem write address
- imem_wdata  out  XLEN  imem write data
- cpu_rst  out  1  reset to the core
- wb_en  in  1  core register-file write enable (WB stage)
- wb_rd  in  5  WB destination register
- wb_data  in  XLEN  WB data
- done  out  1  run finished (terminal state)
- pass  out  1  run passed
- status  out  2  0 idle/running, 1 PASS, 2 FAIL, 3 TIMEOUT
- fail_idx  out  $clog2(NUM_CHECKS)  table index of first mismatch
- cycle_count  out  CNT_W  RUN cycles elapsed

Behaviour:
- Reset values: state=IDLE, cpu_rst=1, ld_ready=0 for one cycle then 1 in IDLE, imem_we=0, imem_addr=0, imem_wdata=0, done=0, pass=0, status=0, fail_idx=0, cycle_count=0, match pointer ptr=0. Table contents are not cleared; imem is not touched.
- States: IDLE, RUN, PASS, FAIL, TMO. All outputs are registered.
- IDLE:
  - ld_ready=1.
  - An accepted load with ld_sel=0 gives imem_we=1, imem_addr=ld_addr, imem_wdata=ld_data on the next cycle (1-cycle latency). imem_we is 0 otherwise.
  - An accepted load with ld_sel=1 writes table[ld_addr mod NUM_CHECKS] = {ld_rd, ld_data}. A later write to the same index overwrites.
  - start latches min(num_exp, NUM_CHECKS) as N and clears ptr and cycle_count. If N=0, next state is PASS; otherwise next state is RUN.
  - start and ld_valid in the same cycle: start wins, the load is not accepted (ld_ready is already 0 next cycle).
- RUN:
  - ld_ready=0, cpu_rst=0 from the first RUN cycle.
  - cycle_count increments every RUN cycle.
  - A writeback is checked when wb_en=1 and wb_rd!=0; x0 writes are ignored.
  - Match (wb_rd==table[ptr].rd && wb_data==table[ptr].data): ptr increments. If ptr==N-1, next state is PASS.
  - Mismatch: fail_idx=ptr, next state is FAIL.
  - cycle_count==TIMEOUT-1 with no terminal event: next state is TMO.
  - Same-cycle priority: FAIL > PASS > TMO.
- PASS/FAIL/TMO:
  - cpu_rst=1 reasserted the cycle after entry.
  - done=1; status = 1/2/3 respectively; pass=1 only in PASS.
  - cycle_count frozen. start and loads ignored. Only rst leaves these states.
- rst in any state, including mid-RUN: IDLE on the next edge with reset values. The core is re-held in reset.
- Wrap: ld_addr beyond IMEM_AW bits is truncated (port width). Table index wraps modulo NUM_CHECKS.

Test Plan:
- Load imem[0..2] = 00500093, 00A00113, 002081B3; table = {x1,5},{x2,10},{x3,15}; start with num_exp=3, core WB drives those writes → status=1, pass=1, done=1, cpu_rst=1 next cycle, imem_we seen 3 times with 1-cycle latency.
- Same setup but table[1]={x2,11} → status=2, fail_idx=1, pass=0.
- num_exp=3 but core writes only x1 → status=3 at cycle_count=TIMEOUT-1 (199).
- WB sequence x0←7, x1←5, x2←10, x3←15 with 3 expectations → x0 ignored, PASS.
- num_exp=0 on start → PASS one cycle later, cpu_rst never deasserted. Also: start and ld_valid in the same cycle → load dropped, ld_ready=0.
- rst asserted mid-RUN after 1 match → next cycle IDLE, cpu_rst=1, cycle_count=0; rerun with unchanged table → PASS.

Source files
------------

// File: rtl/riscv_commit_checker.sv
// Self-checking run controller for the pipelined RISC-V core: loads imem and an
// expected-writeback table, runs the core, and checks writebacks in commit order.
module riscv_commit_checker #(
    parameter int XLEN       = 32,
    parameter int IMEM_AW    = 6,
    parameter int NUM_CHECKS = 8,
    parameter int TIMEOUT    = 200,
    parameter int CNT_W      = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [$clog2(NUM_CHECKS+1)-1:0] num_exp,
    input  logic                            ld_valid,
    output logic                            ld_ready,
    input  logic                            ld_sel,
    input  logic [IMEM_AW-1:0]              ld_addr,
    input  logic [4:0]                      ld_rd,
    input  logic [XLEN-1:0]                 ld_data,
    output logic                            imem_we,
    output logic [IMEM_AW-1:0]              imem_addr,
    output logic [XLEN-1:0]                 imem_wdata,
    output logic                            cpu_rst,
    input  logic                            wb_en,
    input  logic [4:0]                      wb_rd,
    input  logic [XLEN-1:0]                 wb_data,
    output logic                            done,
    output logic                            pass,
    output logic [1:0]                      status,
    output logic [$clog2(NUM_CHECKS)-1:0]   fail_idx,
    output logic [CNT_W-1:0]                cycle_count
);

    localparam int NE_W  = $clog2(NUM_CHECKS + 1);
    localparam int IDX_W = $clog2(NUM_CHECKS);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RUN  = 3'd1;
    localparam logic [2:0] S_PASS = 3'd2;
    localparam logic [2:0] S_FAIL = 3'd3;
    localparam logic [2:0] S_TMO  = 3'd4;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } exp_t;

    exp_t exp_mem [NUM_CHECKS];

    logic [2:0]         state_q, state_d;
    logic               ld_ready_q, ld_ready_d;
    logic               imem_we_q, imem_we_d;
    logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
    logic [XLEN-1:0]    imem_wdata_q, imem_wdata_d;
    logic               cpu_rst_q, cpu_rst_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [1:0]         status_q, status_d;
    logic [IDX_W-1:0]   fail_idx_q, fail_idx_d;
    logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NE_W-1:0]    n_q, n_d;

    logic             ld_fire;
    logic             tbl_we;
    logic [IDX_W-1:0] tbl_idx;
    exp_t             cur_exp;
    logic             wb_chk;
    logic             wb_ok;

    // start takes priority over a same-cycle load.
    assign ld_fire = (state_q == S_IDLE) && ld_valid && ld_ready_q && !start;
    assign tbl_we  = ld_fire && ld_sel;
    assign tbl_idx = IDX_W'(32'(ld_addr) % NUM_CHECKS);
    assign cur_exp = exp_mem[ptr_q];
    assign wb_chk  = wb_en && (wb_rd != 5'd0);
    assign wb_ok   = (wb_rd == cur_exp.rd) && (wb_data == cur_exp.data);

    always_comb begin
        // NOTE: every variable gets a default here so no path leaves it unassigned, which would infer a latch.
        state_d       = state_q;
        ptr_d         = ptr_q;
        n_d           = n_q;
        cycle_count_d = cycle_count_q;
        fail_idx_d    = fail_idx_q;
        imem_we_d     = 1'b0;
        imem_addr_d   = imem_addr_q;
        imem_wdata_d  = imem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d           = (num_exp > NE_W'(NUM_CHECKS)) ? NE_W'(NUM_CHECKS) : num_exp;
                    ptr_d         = '0;
                    cycle_count_d = '0;
                    state_d       = (num_exp == '0) ? S_PASS : S_RUN;
                end else if (ld_fire && !ld_sel) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = ld_addr;
                    imem_wdata_d = ld_data;
                end
            end
            S_RUN: begin
                if (wb_chk && !wb_ok) begin
                    fail_idx_d = ptr_q;
                    state_d    = S_FAIL;
                end else if (wb_chk) begin
                    ptr_d = ptr_q + IDX_W'(1);
                    if (NE_W'(ptr_q) == n_q - NE_W'(1)) begin
                        state_d = S_PASS;
                    end
                end
                // The counter freezes on the cycle the run ends, so a timeout reports TIMEOUT-1.
                if (state_d == S_RUN) begin
                    if (cycle_count_q == CNT_W'(TIMEOUT - 1)) begin
                        state_d = S_TMO;
                    end else begin
                        cycle_count_d = cycle_count_q + CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase

        ld_ready_d = (state_d == S_IDLE);
        cpu_rst_d  = (state_d != S_RUN);
        done_d     = (state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TMO);
        pass_d     = (state_d == S_PASS);
        case (state_d)
            S_PASS:  status_d = 2'd1;
            S_FAIL:  status_d = 2'd2;
            S_TMO:   status_d = 2'd3;
            default: status_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q       <= S_IDLE;
            ld_ready_q    <= 1'b0;
            imem_we_q     <= 1'b0;
            imem_addr_q   <= '0;
            imem_wdata_q  <= '0;
            cpu_rst_q     <= 1'b1;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            status_q      <= 2'd0;
            fail_idx_q    <= '0;
            cycle_count_q <= '0;
            ptr_q         <= '0;
            n_q           <= '0;
        end else begin
            state_q       <= state_d;
            ld_ready_q    <= ld_ready_d;
            imem_we_q     <= imem_we_d;
            imem_addr_q   <= imem_addr_d;
            imem_wdata_q  <= imem_wdata_d;
            cpu_rst_q     <= cpu_rst_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            status_q      <= status_d;
            fail_idx_q    <= fail_idx_d;
            cycle_count_q <= cycle_count_d;
            ptr_q         <= ptr_d;
            n_q           <= n_d;
        end
    end

    // NOTE: the expectation table is storage, not control state; it is deliberately not reset so it survives rst between runs.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            exp_mem[tbl_idx] <= exp_t'({ld_rd, ld_data});
        end
    end

    assign ld_ready    = ld_ready_q;
    assign imem_we     = imem_we_q;
    assign imem_addr   = imem_addr_q;
    assign imem_wdata  = imem_wdata_q;
    assign cpu_rst     = cpu_rst_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign status      = status_q;
    assign fail_idx    = fail_idx_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_riscv_commit_checker.sv
// Randomized self-checking bench for riscv_commit_checker; expected outcomes come
// from a loop-based model that replays the writeback stream against the table.
module tb_riscv_commit_checker;

    localparam int TIMEOUT = 200;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  num_exp;
    logic        ld_valid;
    logic        ld_ready;
    logic        ld_sel;
    logic [5:0]  ld_addr;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        done;
    logic        pass;
    logic [1:0]  status;
    logic [2:0]  fail_idx;
    logic [15:0] cycle_count;

    riscv_commit_checker #(
        .XLEN(32), .IMEM_AW(6), .NUM_CHECKS(8), .TIMEOUT(TIMEOUT), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_exp(num_exp),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel), .ld_addr(ld_addr),
        .ld_rd(ld_rd), .ld_data(ld_data),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .done(done), .pass(pass), .status(status), .fail_idx(fail_idx),
        .cycle_count(cycle_count)
    );

    typedef struct packed {
        logic        en;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    typedef struct packed {
        logic [1:0]  status;
        logic        pass;
        logic        done;
        logic        cpu_rst;
        logic        ld_ready;
        logic [2:0]  fail_idx;
        logic [15:0] count;
        logic        run_rst;
        logic [15:0] end_k;
    } out_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [4:0]  exp_rd   [8];
    logic [31:0] exp_data [8];
    wb_t         wb_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic push_wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
        wb_t w;
        w.en = en; w.rd = rd; w.data = data;
        wb_q.push_back(w);
    endtask

    // One load transfer; the table model follows the index-wrap rule.
    task automatic do_load(input logic sel, input logic [5:0] addr, input logic [4:0] rd,
                           input logic [31:0] data, output logic [38:0] got_now,
                           output logic got_after);
        ld_valid = 1'b1; ld_sel = sel; ld_addr = addr; ld_rd = rd; ld_data = data;
        tick();
        got_now = {imem_we, imem_addr, imem_wdata};
        ld_valid = 1'b0;
        tick();
        got_after = imem_we;
        if (sel) begin
            exp_rd[addr % 8]   = rd;
            exp_data[addr % 8] = data;
        end
    endtask

    function automatic string fmt(input out_t o);
        return $sformatf("st=%0d pass=%0d done=%0d crst=%0d rdy=%0d fidx=%0d cnt=%0d runrst=%0d endk=%0d",
                         o.status, o.pass, o.done, o.cpu_rst, o.ld_ready, o.fail_idx,
                         o.count, o.run_rst, o.end_k);
    endfunction

    // Replays wb_q cycle by cycle against the expected table.
    function automatic out_t model_run(input int n_raw);
        out_t o;
        int   n;
        int   ptr;
        n = (n_raw > 8) ? 8 : n_raw;
        o = '0;
        o.done    = 1'b1;
        o.cpu_rst = 1'b1;
        o.run_rst = (n == 0);
        if (n == 0) begin
            o.status = 2'd1; o.pass = 1'b1; o.end_k = 16'hFFFE;
            return o;
        end
        ptr = 0;
        for (int k = 0; k < TIMEOUT; k++) begin
            wb_t w;
            w = (k < wb_q.size()) ? wb_q[k] : '0;
            if (w.en && w.rd != 5'd0) begin
                if (w.rd == exp_rd[ptr] && w.data == exp_data[ptr]) begin
                    ptr++;
                    if (ptr == n) begin
                        o.status = 2'd1; o.pass = 1'b1; o.count = 16'(k); o.end_k = 16'(k);
                        return o;
                    end
                end else begin
                    o.status = 2'd2; o.fail_idx = 3'(ptr); o.count = 16'(k); o.end_k = 16'(k);
                    return o;
                end
            end
            if (k == TIMEOUT - 1) begin
                o.status = 2'd3; o.count = 16'(k); o.end_k = 16'(k);
            end
        end
        return o;
    endfunction

    // Starts a run, plays wb_q into the WB port, and captures what the DUT shows at the end.
    task automatic do_run(input int n_raw, output out_t o);
        o = '0;
        num_exp = 4'(n_raw);
        start = 1'b1;
        tick();
        start = 1'b0;
        o.run_rst = cpu_rst;
        o.end_k   = 16'hFFFF;
        if (done) begin
            o.end_k = 16'hFFFE;
        end else begin
            for (int k = 0; k < TIMEOUT + 10; k++) begin
                if (k < wb_q.size()) begin
                    wb_en = wb_q[k].en; wb_rd = wb_q[k].rd; wb_data = wb_q[k].data;
                end else begin
                    wb_en = 1'b0; wb_rd = 5'($urandom); wb_data = $urandom;
                end
                tick();
                if (done) begin
                    o.end_k = 16'(k);
                    break;
                end
            end
        end
        wb_en = 1'b0;
        o.status = status; o.pass = pass; o.done = done; o.cpu_rst = cpu_rst;
        o.ld_ready = ld_ready; o.fail_idx = fail_idx; o.count = cycle_count;
    endtask

    task automatic build_golden_wb;
        wb_q.delete();
        push_wb(1'b0, 5'd0, 32'h0);
        push_wb(1'b1, 5'd1, 32'd5);
        push_wb(1'b0, 5'd2, 32'd10);
        push_wb(1'b1, 5'd2, 32'd10);
        push_wb(1'b1, 5'd3, 32'd15);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({ld_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, pass, status, fail_idx, cycle_count}
            !== {1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 16'd0})
            $display("FAIL reset_values: rdy=%0d we=%0d a=%0d d=%h crst=%0d done=%0d pass=%0d st=%0d fidx=%0d cnt=%0d, want rdy=0 we=0 a=0 d=0 crst=1 others 0",
                     ld_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, pass, status, fail_idx, cycle_count);
        else n_pass++;
        tick();
        n_checks++;
        if (ld_ready !== 1'b1) $display("FAIL reset_ready: got %0d want 1", ld_ready);
        else n_pass++;
    endtask

    task automatic test_pass;
        logic [31:0] prog [3];
        logic [38:0] got_now;
        logic        got_after;
        logic        any_we;
        out_t        got, expv;
        prog[0] = 32'h00500093; prog[1] = 32'h00A00113; prog[2] = 32'h002081B3;
        for (int i = 0; i < 3; i++) begin
            do_load(1'b0, 6'(i), 5'd0, prog[i], got_now, got_after);
            n_checks++;
            if ({got_now, got_after} !== {1'b1, 6'(i), prog[i], 1'b0})
                $display("FAIL imem_load%0d: got we/addr/data/we_after=%h want %h", i,
                         {got_now, got_after}, {1'b1, 6'(i), prog[i], 1'b0});
            else n_pass++;
        end
        do_load(1'b1, 6'd0, 5'd1, 32'd5,  got_now, got_after);
        do_load(1'b1, 6'd1, 5'd2, 32'd10, got_now, got_after);
        do_load(1'b1, 6'd2, 5'd3, 32'd15, got_now, got_after);
        n_checks++;
        if ({got_now[38], got_after} !== 2'b00)
            $display("FAIL table_load_no_we: got %b want 00", {got_now[38], got_after});
        else n_pass++;
        build_golden_wb();
        expv = model_run(3);
        do_run(3, got);
        n_checks++;
        if (got !== expv) $display("FAIL pass_run: got %s want %s", fmt(got), fmt(expv));
        else n_pass++;
        // Terminal state must ignore start and loads.
        any_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start = 1'b1; num_exp = 4'd2; ld_valid = 1'b1; ld_sel = 1'b0;
            ld_addr = 6'(i); ld_data = $urandom;
            tick();
            any_we = any_we | imem_we;
        end
        start = 1'b0; ld_valid = 1'b0;
        n_checks++;
        if ({status, done, cycle_count, ld_ready, cpu_rst, any_we} !== {2'd1, 1'b1, expv.count, 1'b0, 1'b1, 1'b0})
            $display("FAIL pass_frozen: got st=%0d done=%0d cnt=%0d rdy=%0d crst=%0d we=%0d want st=1 done=1 cnt=%0d rdy=0 crst=1 we=0",
                     status, done, cycle_count, ld_ready, cpu_rst, any_we, expv.count);
        else n_pass++;
    endtask

    task automatic test_fail;
        logic [38:0] got_now;
        logic        got_after;
        out_t        got, expv;
        apply_reset();
        do_load(1'b1, 6'd1, 5'd2, 32'd11, got_now, got_after);
        build_golden_wb();
        expv = model_run(3);
        do_run(3, got);
        n_checks++;
        if (got !== expv) $display("FAIL fail_run: got %s want %s", fmt(got), fmt(expv));
        else n_pass++;
    endtask

    task automatic test_timeout;
        out_t got, expv;
        apply_reset();
        wb_q.delete();
        push_wb(1'b1, 5'd1, 32'd5);
        expv = model_run(3);
        do_run(3, got);
        n_checks++;
        if (got !== expv) $display("FAIL timeout_run: got %s want %s", fmt(got), fmt(expv));
        else n_pass++;
    endtask

    task automatic test_x0_ignored;
        logic [38:0] got_now;
        logic        got_after;
        out_t        got, expv;
        apply_reset();
        do_load(1'b1, 6'd9, 5'd2, 32'd10, got_now, got_after);  // index 9 wraps to 1
        wb_q.delete();
        push_wb(1'b1, 5'd0, 32'd7);
        push_wb(1'b1, 5'd1, 32'd5);
        push_wb(1'b1, 5'd2, 32'd10);
        push_wb(1'b1, 5'd3, 32'd15);
        expv = model_run(3);
        do_run(3, got);
        n_checks++;
        if (got !== expv) $display("FAIL x0_run: got %s want %s", fmt(got), fmt(expv));
        else n_pass++;
    endtask

    task automatic test_zero_exp;
        logic crst_low;
        logic any_we;
        apply_reset();
        num_exp = 4'd0; start = 1'b1;
        ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 6'd5; ld_data = 32'hDEADBEEF;
        tick();
        start = 1'b0; ld_valid = 1'b0;
        n_checks++;
        if ({ld_ready, imem_we} !== 2'b00)
            $display("FAIL start_drops_load: got rdy=%0d we=%0d want rdy=0 we=0", ld_ready, imem_we);
        else n_pass++;
        n_checks++;
        if ({done, pass, status, cpu_rst} !== {1'b1, 1'b1, 2'd1, 1'b1})
            $display("FAIL zero_exp_pass: got done=%0d pass=%0d st=%0d crst=%0d want 1 1 1 1", done, pass, status, cpu_rst);
        else n_pass++;
        crst_low = 1'b0; any_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            crst_low = crst_low | !cpu_rst;
            any_we   = any_we | imem_we;
        end
        n_checks++;
        if ({crst_low, any_we} !== 2'b00)
            $display("FAIL zero_exp_hold: got crst_low=%0d we=%0d want 0 0", crst_low, any_we);
        else n_pass++;
    endtask

    task automatic test_mid_run_reset;
        out_t got, expv;
        apply_reset();
        num_exp = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
        tick();
        wb_en = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({status, done, pass, cpu_rst, ld_ready, cycle_count} !== {2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0})
            $display("FAIL mid_run_reset: got st=%0d done=%0d pass=%0d crst=%0d rdy=%0d cnt=%0d want 0 0 0 1 0 0",
                     status, done, pass, cpu_rst, ld_ready, cycle_count);
        else n_pass++;
        tick();
        build_golden_wb();
        expv = model_run(3);
        do_run(3, got);
        n_checks++;
        if (got !== expv) $display("FAIL rerun_after_reset: got %s want %s", fmt(got), fmt(expv));
        else n_pass++;
    endtask

    task automatic test_random;
        logic [38:0] got_now;
        logic        got_after;
        apply_reset();
        for (int i = 0; i < 8; i++)
            do_load(1'b1, 6'(i), 5'($urandom_range(1, 31)), $urandom, got_now, got_after);
        for (int it = 0; it < 12; it++) begin
            out_t got, expv;
            int   n_raw;
            int   nn;
            int   nl;
            apply_reset();
            nl = $urandom_range(0, 4);
            for (int j = 0; j < nl; j++)
                do_load(1'b1, 6'($urandom_range(0, 63)), 5'($urandom_range(1, 31)), $urandom,
                        got_now, got_after);
            n_raw = $urandom_range(0, 11);
            nn = (n_raw > 8) ? 8 : n_raw;
            wb_q.delete();
            for (int i = 0; i < nn; i++) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    if ($urandom_range(0, 1) == 1) push_wb(1'b1, 5'd0, $urandom);
                    else push_wb(1'b0, 5'($urandom), $urandom);
                end
                if ($urandom_range(0, 9) == 0) push_wb(1'b1, exp_rd[i], exp_data[i] ^ 32'h1);
                else push_wb(1'b1, exp_rd[i], exp_data[i]);
            end
            if ($urandom_range(0, 4) == 0 && wb_q.size() > 0) void'(wb_q.pop_back());
            expv = model_run(n_raw);
            do_run(n_raw, got);
            n_checks++;
            if (got !== expv) $display("FAIL random_run%0d (n=%0d): got %s want %s", it, n_raw, fmt(got), fmt(expv));
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_exp = '0; ld_valid = 1'b0; ld_sel = 1'b0;
        ld_addr = '0; ld_rd = '0; ld_data = '0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        for (int i = 0; i < 8; i++) begin
            exp_rd[i] = '0; exp_data[i] = '0;
        end
        test_reset();
        test_pass();
        test_fail();
        test_timeout();
        test_x0_ignored();
        test_zero_exp();
        test_mid_run_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
